// File: rtl/soh_nn_pkg.sv
// soh_nn_pkg: shared constants, weight RAM layout and FSM encoding for the
// 4-64-32-16-1 SoH regressor sequencer.
package soh_nn_pkg;

   localparam int IN_SIZE = 4;
   localparam int L1_SIZE = 64;
   localparam int L2_SIZE = 32;
   localparam int L3_SIZE = 16;
   localparam int L4_SIZE = 1;
   localparam int DATA_W  = 32;
   localparam int FRAC_W  = 16;
   localparam int ADDR_W  = 12;

   // Weight RAM layout: per neuron [bias, w0 .. w(K-1)], layers back to back
   localparam int L1_BASE    = 0;
   localparam int L2_BASE    = 320;
   localparam int L3_BASE    = 2400;
   localparam int L4_BASE    = 2928;
   localparam int WMEM_WORDS = 2945;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAC,
      ST_ACC_LAST,
      ST_DONE
   } state_t;

   // Fan-in K of a layer (0-based layer index)
   function automatic logic [6:0] layer_fan_in(input logic [1:0] layer);
      case (layer)
         2'd0:    return 7'(IN_SIZE);
         2'd1:    return 7'(L1_SIZE);
         2'd2:    return 7'(L2_SIZE);
         default: return 7'(L3_SIZE);
      endcase
   endfunction

   // Neuron count of a layer
   function automatic logic [6:0] layer_size(input logic [1:0] layer);
      case (layer)
         2'd0:    return 7'(L1_SIZE);
         2'd1:    return 7'(L2_SIZE);
         2'd2:    return 7'(L3_SIZE);
         default: return 7'(L4_SIZE);
      endcase
   endfunction

   // First weight RAM word of a layer
   function automatic logic [ADDR_W-1:0] layer_base(input logic [1:0] layer);
      case (layer)
         2'd0:    return ADDR_W'(L1_BASE);
         2'd1:    return ADDR_W'(L2_BASE);
         2'd2:    return ADDR_W'(L3_BASE);
         default: return ADDR_W'(L4_BASE);
      endcase
   endfunction

endpackage

// File: rtl/soh_mac_unit.sv
// soh_mac_unit: shared Q16.16 multiply-accumulate. A product is formed 32x32
// signed -> 64, shifted right arithmetically by FRAC_W and truncated to one
// word, then added to the accumulator. acc_next is the value the accumulator
// takes at the coming edge, so the sequencer can store a finished neuron
// without an extra cycle.
// Build option: SOH_MAC_SAT_EN saturates truncation and accumulate instead of
// wrapping modulo 2^32.
module soh_mac_unit
   import soh_nn_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load_bias,
   input  logic              accumulate,
   input  logic [DATA_W-1:0] act,
   input  logic [DATA_W-1:0] weight,
   output logic [DATA_W-1:0] acc_next
);

   logic [DATA_W-1:0]          acc;
   logic signed [2*DATA_W-1:0] act_ext;
   logic signed [2*DATA_W-1:0] weight_ext;
   logic signed [2*DATA_W-1:0] product;
   logic signed [2*DATA_W-1:0] shifted;
   logic [DATA_W-1:0]          term;
   logic [DATA_W-1:0]          sum;

`ifdef SOH_MAC_SAT_EN
   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   logic [DATA_W:0] wide_sum;
`else
   logic unused_high;
   assign unused_high = ^shifted[2*DATA_W-1:DATA_W];
`endif

   // Product, fixed-point rescale and reduction to one data word
   always_comb begin
      // NOTE: every signal of an always_comb gets a value on every path, so no latch can be inferred.
      act_ext    = {{DATA_W{act[DATA_W-1]}}, act};
      weight_ext = {{DATA_W{weight[DATA_W-1]}}, weight};
      product    = act_ext * weight_ext;
      shifted    = product >>> FRAC_W;
`ifdef SOH_MAC_SAT_EN
      if (shifted[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){shifted[2*DATA_W-1]}})
         term = shifted[2*DATA_W-1] ? SAT_MIN : SAT_MAX;
      else
         term = shifted[DATA_W-1:0];
`else
      term = shifted[DATA_W-1:0];
`endif
   end

   // Accumulate step and next-accumulator selection
   always_comb begin
`ifdef SOH_MAC_SAT_EN
      wide_sum = {acc[DATA_W-1], acc} + {term[DATA_W-1], term};
      if (wide_sum[DATA_W] != wide_sum[DATA_W-1])
         sum = wide_sum[DATA_W] ? SAT_MIN : SAT_MAX;
      else
         sum = wide_sum[DATA_W-1:0];
`else
      sum = acc + term;
`endif
      acc_next = acc;
      if (clear)
         acc_next = '0;
      else if (load_bias)
         acc_next = weight;
      else if (accumulate)
         acc_next = sum;
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset)
         acc <= '0;
      else
         acc <= acc_next;
   end

endmodule

// File: rtl/soh_mlp_sequencer.sv
// soh_mlp_sequencer: runs the 4-64-32-16-1 SoH regressor on one shared MAC.
// Weights stream from an external 1-cycle-latency RAM strictly in address
// order; activations ping-pong between buffers A and B; one Q16.16 result is
// returned over valid/ready.
// Build option: SOH_MAC_SAT_EN (see soh_mac_unit) selects saturating MAC math.
module soh_mlp_sequencer
   import soh_nn_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IN_SIZE*DATA_W-1:0] in_data,
   output logic                      wmem_rd_en,
   output logic [ADDR_W-1:0]         wmem_addr,
   input  logic [DATA_W-1:0]         wmem_rdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         soh_out,
   output logic                      busy
);

   state_t            state;
   logic [1:0]        layer;
   logic [5:0]        neuron;
   logic [6:0]        idx;        // MAC cycle within a neuron; weight w(idx-1) arrives now
   logic [DATA_W-1:0] buf_a [0:L1_SIZE-1];
   logic [DATA_W-1:0] buf_b [0:L1_SIZE-1];

   logic [6:0]        fan_in;
   logic [6:0]        n_count;
   logic [5:0]        act_idx;
   logic [DATA_W-1:0] act;
   logic [DATA_W-1:0] acc_next;
   logic [DATA_W-1:0] relu_val;
   logic              accept;
   logic              last_weight;
   logic              last_neuron;
   logic              mac_load;
   logic              mac_acc;
   logic              wr_en;

   assign fan_in      = layer_fan_in(layer);
   assign n_count     = layer_size(layer);
   assign accept      = in_valid && in_ready;
   assign last_weight = (idx == fan_in - 7'd1);
   assign last_neuron = ({1'b0, neuron} == n_count - 7'd1);
   assign act_idx     = 6'(idx - 7'd1);
   // Layers 1 and 3 read A, layers 2 and 4 read B
   assign act         = layer[0] ? buf_b[act_idx] : buf_a[act_idx];
   assign mac_load    = (state == ST_MAC) && (idx == 7'd0);
   assign mac_acc     = ((state == ST_MAC) && (idx != 7'd0)) || (state == ST_ACC_LAST);
   assign wr_en       = (state == ST_ACC_LAST) && (layer != 2'd3);
   assign relu_val    = acc_next[DATA_W-1] ? '0 : acc_next;

   soh_mac_unit u_mac (
      .clk        (clk),
      .reset      (reset),
      .clear      (accept),
      .load_bias  (mac_load),
      .accumulate (mac_acc),
      .act        (act),
      .weight     (wmem_rdata),
      .acc_next   (acc_next)
   );

   // Activation buffers: input vector into A, hidden results ping-pong A/B
   always_ff @(posedge clk) begin
      // NOTE: the buffers are storage only; they are left out of reset so they can map to RAM and survive an abort.
      if (accept) begin
         for (int j = 0; j < IN_SIZE; j++)
            buf_a[j] <= in_data[(IN_SIZE-1-j)*DATA_W +: DATA_W];
      end else if (wr_en && (layer == 2'd1)) begin
         buf_a[neuron] <= relu_val;
      end
      if (wr_en && (layer != 2'd1))
         buf_b[neuron] <= relu_val;
   end

   // Control FSM with registered handshake and weight RAM outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         layer      <= 2'd0;
         neuron     <= 6'd0;
         idx        <= 7'd0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         soh_out    <= '0;
         wmem_rd_en <= 1'b0;
         wmem_addr  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_LOAD;
                  layer      <= 2'd0;
                  neuron     <= 6'd0;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  wmem_rd_en <= 1'b1;
                  wmem_addr  <= layer_base(2'd0);
               end
            end
            ST_LOAD: begin
               state     <= ST_MAC;
               idx       <= 7'd0;
               wmem_addr <= wmem_addr + ADDR_W'(1);
            end
            ST_MAC: begin
               idx <= idx + 7'd1;
               if (last_weight) begin
                  state      <= ST_ACC_LAST;
                  wmem_rd_en <= 1'b0;
               end else begin
                  wmem_addr <= wmem_addr + ADDR_W'(1);
               end
            end
            ST_ACC_LAST: begin
               if (last_neuron && (layer == 2'd3)) begin
                  state     <= ST_DONE;
                  neuron    <= 6'd0;
                  out_valid <= 1'b1;
                  soh_out   <= acc_next;
               end else if (last_neuron) begin
                  state      <= ST_LOAD;
                  neuron     <= 6'd0;
                  layer      <= layer + 2'd1;
                  wmem_rd_en <= 1'b1;
                  wmem_addr  <= layer_base(layer + 2'd1);
               end else begin
                  state      <= ST_LOAD;
                  neuron     <= neuron + 6'd1;
                  wmem_rd_en <= 1'b1;
                  wmem_addr  <= wmem_addr + ADDR_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
